log_ring_buffer: RTL and testbench

Parametrised circular log buffer between the capture front-end and the UART line transmitter. Stores `DATA_WIDTH`-bit log entries in a power-of-two ring and drains them one line at a time under the transmitter handshake. Full-buffer policy is selectable at run time: drop newest or overwrite oldest. Lost entries are counted. Zero-valued entries are legal data; validity is tracked by occupancy, not by sentinel.

---
 rtl/log_pkg.sv | 12 +
 rtl/log_ring_mem.sv | 30 +++
 rtl/log_ring_buffer.sv | 119 +++++++++++
 tb/tb_log_ring_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared types and default sizes for the log ring buffer and its storage.
package log_pkg;

    localparam int LOG_DATA_WIDTH = 32;
    localparam int LOG_ADDR_WIDTH = 8;
    localparam int LOG_DROP_WIDTH = 16;

    typedef logic [LOG_DATA_WIDTH-1:0] log_file_t;
    typedef logic [LOG_ADDR_WIDTH-1:0] addr_t;
    typedef logic [LOG_ADDR_WIDTH:0]   count_t;

endpackage

// File: rtl/log_ring_mem.sv
// Simple dual-port storage for the log ring: one write port, one registered read port.
module log_ring_mem
    import log_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int ADDR_WIDTH = LOG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Read-first: a same-address write in the same cycle returns the old entry,
    // which is what a full-buffer push+pop needs.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/log_ring_buffer.sv
// Circular log buffer feeding the UART line transmitter, with drop/overwrite full policy.
module log_ring_buffer
    import log_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int ADDR_WIDTH = LOG_ADDR_WIDTH,
    parameter int DROP_WIDTH = LOG_DROP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  overwrite_mode,
    input  logic                  flush,
    input  logic                  line_transmitted,
    output logic                  line_trans_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  log_empty,
    output logic                  log_full,
    output logic [ADDR_WIDTH:0]   log_count,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [DROP_WIDTH-1:0] drop_reg, drop_next;
    logic                  pulse_reg, empty_reg, full_reg, rd_valid_reg;
    logic                  pop, push_counted, mem_we, drop_event;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The outstanding pulse blocks a second pop so each line gets its own strobe.
    assign pop          = line_transmitted & ~empty_reg & ~pulse_reg & ~flush;
    assign push_counted = write_en & ~flush & (~full_reg | pop);

    always_comb begin
        mem_we      = 1'b0;
        drop_event  = 1'b0;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        drop_next   = drop_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            drop_next   = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push_counted) begin
                mem_we      = 1'b1;
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end else if (write_en) begin
                drop_event = 1'b1;
                if (overwrite_mode) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                end
            end
            if (push_counted && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push_counted) begin
                count_next = count_reg - 1'b1;
            end
            if (drop_event && drop_reg != {DROP_WIDTH{1'b1}}) begin
                drop_next = drop_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_reg     <= '0;
            pulse_reg    <= 1'b0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            drop_reg     <= drop_next;
            pulse_reg    <= pop;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == FULL_COUNT);
            rd_valid_reg <= rd_valid_reg | pop;
        end
    end

    log_ring_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (write_data),
        .re    (pop),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    // RAM output has no reset; mask it until the first pop after reset.
    assign read_data     = rd_valid_reg ? mem_rdata : '0;
    assign line_trans_en = pulse_reg;
    assign log_empty     = empty_reg;
    assign log_full      = full_reg;
    assign log_count     = count_reg;
    assign drop_count    = drop_reg;

endmodule

// File: tb/tb_log_ring_buffer.sv
// Queue-based reference model of the log ring buffer, directed scenarios plus random traffic.
module tb_log_ring_buffer;

    localparam int DW       = 32;
    localparam int AW       = 3;
    localparam int DEPTH    = 8;
    localparam int DRW      = 4;
    localparam int DROP_MAX = (1 << DRW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          overwrite_mode = 1'b0;
    logic          flush = 1'b0;
    logic          line_transmitted = 1'b0;
    logic          line_trans_en;
    logic [DW-1:0] read_data;
    logic          log_empty;
    logic          log_full;
    logic [AW:0]   log_count;
    logic [DRW-1:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mq[$];
    int            m_drops = 0;
    bit            m_pulse = 0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] seen[$];
    logic [DW-1:0] exp_q[$];

    log_ring_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DROP_WIDTH(DRW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .write_en         (write_en),
        .write_data       (write_data),
        .overwrite_mode   (overwrite_mode),
        .flush            (flush),
        .line_transmitted (line_transmitted),
        .line_trans_en    (line_trans_en),
        .read_data        (read_data),
        .log_empty        (log_empty),
        .log_full         (log_full),
        .log_count        (log_count),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Advance one clock: evolve the model from the pre-edge inputs, then compare every output.
    task automatic step();
        logic [DW-1:0] nq[$];
        logic [DW-1:0] nr;
        int            nd;
        bit            np;
        bit            pop;
        nq  = mq;
        nd  = m_drops;
        np  = m_pulse;
        nr  = m_rdata;
        pop = 0;
        if (!rst) begin
            nq.delete();
            nd = 0;
            np = 0;
            nr = '0;
        end else if (flush) begin
            nq.delete();
            nd = 0;
            np = 0;
        end else begin
            pop = line_transmitted && (nq.size() > 0) && !m_pulse;
            np  = pop;
            if (pop) nr = nq.pop_front();
            if (write_en) begin
                if (nq.size() < DEPTH) begin
                    nq.push_back(write_data);
                end else begin
                    if (nd < DROP_MAX) nd++;
                    if (overwrite_mode) begin
                        void'(nq.pop_front());
                        nq.push_back(write_data);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        mq      = nq;
        m_drops = nd;
        m_pulse = np;
        m_rdata = nr;
        chk("line_trans_en", line_trans_en, m_pulse);
        chk("read_data", read_data, m_rdata);
        chk("log_empty", log_empty, mq.size() == 0);
        chk("log_full", log_full, mq.size() == DEPTH);
        chk("log_count", log_count, mq.size());
        chk("drop_count", drop_count, m_drops);
        if (line_trans_en) seen.push_back(read_data);
    endtask

    task automatic push(input logic [DW-1:0] d);
        write_en   = 1'b1;
        write_data = d;
        step();
        write_en   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic drain(input int cycles);
        seen.delete();
        line_transmitted = 1'b1;
        repeat (cycles) step();
        line_transmitted = 1'b0;
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, seen.size(), exp_q.size());
        for (int i = 0; i < seen.size() && i < exp_q.size(); i++) begin
            chk(name, seen[i], exp_q[i]);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_trans_en", line_trans_en, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_empty", log_empty, 1);
        chk("rst_full", log_full, 0);
        chk("rst_count", log_count, 0);
        chk("rst_drop", drop_count, 0);
        rst = 1'b1;
        step();

        // Basic in-order drain with 2-cycle pulse spacing
        for (int i = 0; i < 5; i++) push(32'hA1 + i);
        chk("fill5_count", log_count, 5);
        drain(12);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'hA1 + i);
        check_seq("drain_a");
        chk("drain_a_empty", log_empty, 1);

        // Drop-newest when full
        do_flush();
        overwrite_mode = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h30 + i);
        push(32'hFF);
        push(32'hFF);
        chk("dropnew_full", log_full, 1);
        chk("dropnew_drops", drop_count, 2);
        drain(18);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h30 + i);
        check_seq("drain_dropnew");

        // Overwrite-oldest when full
        do_flush();
        for (int i = 0; i < 8; i++) push(32'h10 + i);
        overwrite_mode = 1'b1;
        push(32'h20);
        push(32'h21);
        overwrite_mode = 1'b0;
        chk("ovw_drops", drop_count, 2);
        drain(18);
        exp_q.delete();
        for (int i = 2; i < 8; i++) exp_q.push_back(32'h10 + i);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h21);
        check_seq("drain_ovw");

        // Push and pop in the same cycle while full
        do_flush();
        for (int i = 0; i < 8; i++) push(32'h40 + i);
        seen.delete();
        line_transmitted = 1'b1;
        write_en = 1'b1;
        write_data = 32'h55;
        step();
        write_en = 1'b0;
        chk("pp_count", log_count, 8);
        chk("pp_drops", drop_count, 0);
        chk("pp_pulse", line_trans_en, 1);
        repeat (20) step();
        line_transmitted = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + i);
        exp_q.push_back(32'h55);
        check_seq("drain_pp");

        // Zero is valid data
        do_flush();
        push(32'h0);
        drain(4);
        exp_q.delete();
        exp_q.push_back(32'h0);
        check_seq("drain_zero");

        // Flush beats a simultaneous write
        do_flush();
        for (int i = 0; i < 5; i++) push(32'h60 + i);
        flush = 1'b1;
        write_en = 1'b1;
        write_data = 32'h99;
        step();
        flush = 1'b0;
        write_en = 1'b0;
        chk("flush_count", log_count, 0);
        chk("flush_empty", log_empty, 1);
        chk("flush_drops", drop_count, 0);
        chk("flush_pulse", line_trans_en, 0);

        // Reset in the middle of a drain
        for (int i = 0; i < 4; i++) push(32'h70 + i);
        line_transmitted = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rstmid_pulse", line_trans_en, 0);
        chk("rstmid_read_data", read_data, 0);
        chk("rstmid_empty", log_empty, 1);
        chk("rstmid_full", log_full, 0);
        chk("rstmid_count", log_count, 0);
        chk("rstmid_drops", drop_count, 0);
        rst = 1'b1;
        line_transmitted = 1'b0;
        step();

        // Random traffic with phased write/read pressure to reach full, empty and drop saturation
        for (int c = 0; c < 4000; c++) begin
            int wr_bias;
            int rd_bias;
            wr_bias = ((c / 256) % 3 == 0) ? 90 : (((c / 256) % 3 == 1) ? 50 : 20);
            rd_bias = ((c / 256) % 3 == 0) ? 10 : 70;
            rst              = ($urandom_range(0, 499) != 0);
            flush            = ($urandom_range(0, 149) == 0);
            write_en         = ($urandom_range(0, 99) < wr_bias);
            write_data       = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            overwrite_mode   = $urandom_range(0, 1);
            line_transmitted = ($urandom_range(0, 99) < rd_bias);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
